// File: rtl/video_out_stage_if.sv
// Pixel-pipeline to pad-stage bundle: timing/colour inputs plus the pad-bound outputs.
// master = pixel pipeline side, slave = video_out_stage.
interface video_out_stage_if;
  logic        hsync_in;
  logic        vsync_in;
  logic        viden_in;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [15:0] frame;
  logic        sync_err;
  logic        locked;

  modport master (
    output hsync_in, vsync_in, viden_in, r_in, g_in, b_in,
    input  hsync, vsync, blank_n, r, g, b, frame, sync_err, locked
  );

  modport slave (
    input  hsync_in, vsync_in, viden_in, r_in, g_in, b_in,
    output hsync, vsync, blank_n, r, g, b, frame, sync_err, locked
  );
endinterface

// File: rtl/video_out_stage.sv
// Final registered video stage: sync/enable delay line, blanking, frame counter.
// Sync timing checker (SYNC_ERR/LOCKED) is built only when VIDEO_SYNC_CHECK_EN is defined.
module video_out_stage #(
  parameter int SYNC_DLY = 2,
  parameter int SYNC_POL = 1,
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 628
) (
  input  logic             vidclk,
  input  logic             rst,
  video_out_stage_if.slave vid
);

  localparam logic       ACT      = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic       INACT    = ~ACT;
  localparam logic [2:0] DLY_IDLE = {INACT, INACT, 1'b0};
  localparam int         LAST     = SYNC_DLY - 1;

  // A total of all-ones can never match because a saturated counter is a mismatch.
  if (SYNC_DLY < 1 || SYNC_DLY > 8 || H_TOTAL < 1 || H_TOTAL > 4094 ||
      V_TOTAL < 1 || V_TOTAL > 2046) begin : g_bad_param
    $error("video_out_stage: parameter out of range");
  end

  // Each delay stage holds {hsync, vsync, viden}.
  logic [SYNC_DLY-1:0][2:0] dly_q, dly_d;
  logic [23:0]              rgb_q, rgb_d;
  logic                     vs_out_prev_q, vs_out_prev_d;
  logic [15:0]              frame_q, frame_d;

  always_comb begin
    dly_d    = dly_q;
    dly_d[0] = {vid.hsync_in, vid.vsync_in, vid.viden_in};
    for (int i = 1; i < SYNC_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    // Gate with the enable that lands in the last stage this edge, so colour and BLANK_N align.
    if (dly_d[LAST][0]) begin
      rgb_d = {vid.r_in, vid.g_in, vid.b_in};
    end else begin
      rgb_d = 24'h000000;
    end
    vs_out_prev_d = dly_q[LAST][1];
    if ((dly_q[LAST][1] == ACT) && (vs_out_prev_q == INACT)) begin
      frame_d = frame_q + 16'd1;
    end else begin
      frame_d = frame_q;
    end
  end

  always_ff @(posedge vidclk or posedge rst) begin
    if (rst) begin
      dly_q         <= {SYNC_DLY{DLY_IDLE}};
      rgb_q         <= 24'h000000;
      vs_out_prev_q <= INACT;
      frame_q       <= 16'h0000;
    end else begin
      dly_q         <= dly_d;
      rgb_q         <= rgb_d;
      vs_out_prev_q <= vs_out_prev_d;
      frame_q       <= frame_d;
    end
  end

  assign vid.hsync   = dly_q[LAST][2];
  assign vid.vsync   = dly_q[LAST][1];
  assign vid.blank_n = dly_q[LAST][0];
  assign vid.r       = rgb_q[23:16];
  assign vid.g       = rgb_q[15:8];
  assign vid.b       = rgb_q[7:0];
  assign vid.frame   = frame_q;

`ifdef VIDEO_SYNC_CHECK_EN
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_GOOD1    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_st_e;

  localparam logic [11:0] H_EXP = 12'(H_TOTAL);
  localparam logic [10:0] V_EXP = 11'(V_TOTAL);

  lock_st_e    st_q, st_d;
  logic        hs_in_q, hs_in_d, hs_in_prev_q, hs_in_prev_d;
  logic        vs_in_q, vs_in_d, vs_in_prev_q, vs_in_prev_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic        line_seen_bad_q, line_seen_bad_d;
  logic        sync_err_q, sync_err_d, locked_q, locked_d;
  logic [10:0] vcnt_inc_s;
  logic        hs_edge_s, vs_edge_s, line_bad_s, frame_bad_s, frame_good_s;

  always_comb begin
    hs_in_d         = vid.hsync_in;
    hs_in_prev_d    = hs_in_q;
    vs_in_d         = vid.vsync_in;
    vs_in_prev_d    = vs_in_q;
    hs_edge_s       = (hs_in_q == ACT) && (hs_in_prev_q == INACT);
    vs_edge_s       = (vs_in_q == ACT) && (vs_in_prev_q == INACT);
    hcnt_d          = hcnt_q;
    vcnt_d          = vcnt_q;
    vcnt_inc_s      = vcnt_q;
    h_armed_d       = h_armed_q;
    v_armed_d       = v_armed_q;
    line_seen_bad_d = line_seen_bad_q;
    line_bad_s      = 1'b0;
    frame_bad_s     = 1'b0;
    frame_good_s    = 1'b0;

    // hcnt restarts at 1 so it reads exactly the line length on the next edge.
    if (hs_edge_s) begin
      line_bad_s = h_armed_q && ((hcnt_q != H_EXP) || (hcnt_q == 12'hFFF));
      h_armed_d  = 1'b1;
      hcnt_d     = 12'd1;
      vcnt_inc_s = (vcnt_q == 11'h7FF) ? vcnt_q : (vcnt_q + 11'd1);
    end else begin
      hcnt_d     = (hcnt_q == 12'hFFF) ? hcnt_q : (hcnt_q + 12'd1);
    end

    // A coincident line edge belongs to the frame that is ending.
    if (vs_edge_s) begin
      frame_bad_s     = v_armed_q && ((vcnt_inc_s != V_EXP) || (vcnt_inc_s == 11'h7FF));
      frame_good_s    = v_armed_q && !frame_bad_s && !line_bad_s && !line_seen_bad_q;
      v_armed_d       = 1'b1;
      vcnt_d          = 11'd0;
      line_seen_bad_d = 1'b0;
    end else begin
      vcnt_d          = vcnt_inc_s;
      line_seen_bad_d = line_seen_bad_q | line_bad_s;
    end

    sync_err_d = sync_err_q | line_bad_s | frame_bad_s;
    if (line_bad_s || frame_bad_s) begin
      st_d = ST_UNLOCKED;
    end else if (frame_good_s) begin
      case (st_q)
        ST_UNLOCKED: st_d = ST_GOOD1;
        ST_GOOD1:    st_d = ST_LOCKED;
        ST_LOCKED:   st_d = ST_LOCKED;
        default:     st_d = ST_UNLOCKED;
      endcase
    end else begin
      st_d = st_q;
    end
    locked_d = (st_d == ST_LOCKED);
  end

  always_ff @(posedge vidclk or posedge rst) begin
    if (rst) begin
      st_q            <= ST_UNLOCKED;
      hs_in_q         <= INACT;
      hs_in_prev_q    <= INACT;
      vs_in_q         <= INACT;
      vs_in_prev_q    <= INACT;
      hcnt_q          <= 12'd0;
      vcnt_q          <= 11'd0;
      h_armed_q       <= 1'b0;
      v_armed_q       <= 1'b0;
      line_seen_bad_q <= 1'b0;
      sync_err_q      <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      st_q            <= st_d;
      hs_in_q         <= hs_in_d;
      hs_in_prev_q    <= hs_in_prev_d;
      vs_in_q         <= vs_in_d;
      vs_in_prev_q    <= vs_in_prev_d;
      hcnt_q          <= hcnt_d;
      vcnt_q          <= vcnt_d;
      h_armed_q       <= h_armed_d;
      v_armed_q       <= v_armed_d;
      line_seen_bad_q <= line_seen_bad_d;
      sync_err_q      <= sync_err_d;
      locked_q        <= locked_d;
    end
  end

  assign vid.sync_err = sync_err_q;
  assign vid.locked   = locked_q;
`else
  assign vid.sync_err = 1'b0;
  assign vid.locked   = 1'b0;
`endif

endmodule
